// File: rtl/busarb_pkg.sv
// busarb_pkg: shared types for the two-master bus arbiter.
package busarb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;
  typedef struct packed {
    logic        vld;
    logic [31:0] rdata;
    logic        resp;
  } rsp_buf_t;
endpackage

// File: rtl/busarb_rspbuf.sv
// busarb_rspbuf: per-master response buffer with capture/clear and response bypass mux.
module busarb_rspbuf
  import busarb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        own_i,
  input  logic        gnt_i,
  input  logic        htrans_i,
  input  logic        hready_i,
  input  logic [31:0] hrdata_i,
  input  logic        hresp_i,
  output logic [31:0] hrdata_o,
  output logic        hresp_o,
  output logic        hready_o
);
  rsp_buf_t rb_q, rb_d;
  logic go, cap;
  always_comb begin
    go = gnt_i | !htrans_i;
    cap = hready_i & own_i & htrans_i & !gnt_i;
    rb_d = cap ? '{vld: 1'b1, rdata: hrdata_i, resp: hresp_i} : go ? '0 : rb_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) rb_q <= '0;
    else     rb_q <= rb_d;
  // A buffered response frees the master from the slave's hready.
  assign hready_o = (rb_q.vld | !own_i) ? go : hready_i & go;
  assign hrdata_o = rb_q.vld ? rb_q.rdata : hrdata_i;
  assign hresp_o  = rb_q.vld ? rb_q.resp : hresp_i;
endmodule

// File: rtl/busarb.sv
// busarb: fixed-priority I/D bus arbiter with starvation relief and data-phase response routing.
module busarb
  import busarb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_haddr,
  input  logic [1:0]  i_hsize,
  input  logic        i_hwrite,
  input  logic        i_hprot,
  input  logic        i_htrans,
  input  logic [31:0] i_hwdata,
  output logic [31:0] i_hrdata,
  output logic        i_hresp,
  output logic        i_hready,
  input  logic [31:0] d_haddr,
  input  logic [1:0]  d_hsize,
  input  logic        d_hwrite,
  input  logic        d_hprot,
  input  logic        d_htrans,
  input  logic [31:0] d_hwdata,
  output logic [31:0] d_hrdata,
  output logic        d_hresp,
  output logic        d_hready,
  output logic [31:0] haddr,
  output logic [1:0]  hsize,
  output logic        hwrite,
  output logic        hprot,
  output logic        htrans,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hresp,
  input  logic        hready
);
  localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  owner_e dp_own_q, dp_own_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic starved, gnt_i, gnt_d;
  always_comb begin
    starved = (STARVE_LIMIT != 0) && (cnt_q == LIM);
    gnt_d = hready & d_htrans & !(i_htrans & starved);
    gnt_i = hready & i_htrans & !gnt_d;
    haddr = gnt_i ? i_haddr : d_haddr;
    hsize = gnt_i ? i_hsize : d_hsize;
    hwrite = gnt_i ? i_hwrite : d_hwrite;
    hprot = gnt_i ? i_hprot : d_hprot;
    htrans = gnt_i | gnt_d;
    hwdata = dp_own_q == OWN_I ? i_hwdata : dp_own_q == OWN_D ? d_hwdata : '0;
    dp_own_d = !hready ? dp_own_q : gnt_i ? OWN_I : gnt_d ? OWN_D : OWN_NONE;
    cnt_d = (gnt_i | !i_htrans) ? '0 : (gnt_d && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dp_own_q <= OWN_NONE;
      cnt_q <= '0;
    end else begin
      dp_own_q <= dp_own_d;
      cnt_q <= cnt_d;
    end
  busarb_rspbuf u_ibuf (
    .clk(clk), .rst(rst), .own_i(dp_own_q == OWN_I), .gnt_i(gnt_i), .htrans_i(i_htrans),
    .hready_i(hready), .hrdata_i(hrdata), .hresp_i(hresp),
    .hrdata_o(i_hrdata), .hresp_o(i_hresp), .hready_o(i_hready)
  );
  busarb_rspbuf u_dbuf (
    .clk(clk), .rst(rst), .own_i(dp_own_q == OWN_D), .gnt_i(gnt_d), .htrans_i(d_htrans),
    .hready_i(hready), .hrdata_i(hrdata), .hresp_i(hresp),
    .hrdata_o(d_hrdata), .hresp_o(d_hresp), .hready_o(d_hready)
  );
endmodule
